p2s_rr_scheduler: RTL and testbench

Round-robin scheduler that shares one parallel-to-serial shift path among `NUM_REQ` requesters. It arbitrates pending requests, captures the winner's word and acknowledges it, then serializes the word MSB-first on a single serial line. Each frame is marked with a valid strobe, a start-of-frame pulse and the source index. It sits between the parallel producers and the serial link, replacing per-producer converters.

---
 rtl/p2s_sched_pkg.sv | 41 ++++
 rtl/p2s_shift_reg.sv | 36 +++
 rtl/p2s_rr_scheduler.sv | 119 +++++++++++
 tb/tb_p2s_rr_scheduler.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/p2s_sched_pkg.sv
// Shared types and the round-robin search used by the serial scheduler.
package p2s_sched_pkg;

  // Upper bound on requesters the search helper can handle; the index
  // field of pick_t is sized to match.
  localparam int MAX_REQ = 32;
  localparam int IDX_W   = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } pick_t;

  // Search starts one past the last winner and wraps by explicit comparison
  // against numReq-1, so any requester count up to MAX_REQ works.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] request,
                                    input int lastGrant,
                                    input int numReq);
    pick_t res;
    int    cand;
    res  = '0;
    cand = lastGrant;
    for (int off = 0; off < MAX_REQ; off++) begin
      if (off < numReq) begin
        cand = (cand == numReq - 1) ? 0 : cand + 1;
        if (!res.found && request[cand[IDX_W-1:0]]) begin
          res.found = 1'b1;
          res.idx   = cand[IDX_W-1:0];
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/p2s_shift_reg.sv
// Parallel-load, MSB-first shift register with zero fill.
module p2s_shift_reg #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  shift,
  input  logic [DATA_WIDTH-1:0] din,
  output logic                  msb
);

  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;

  // Load wins over shift; shifting moves the next bit into the MSB slot.
  always_comb begin
    shreg_d = shreg_q;
    if (load) begin
      shreg_d = din;
    end else if (shift) begin
      shreg_d = {shreg_q[DATA_WIDTH-2:0], 1'b0};
    end
  end

  // Register the shift contents; reset clears any word in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg_q <= '0;
    end else begin
      shreg_q <= shreg_d;
    end
  end

  assign msb = shreg_q[DATA_WIDTH-1];

endmodule

// File: rtl/p2s_rr_scheduler.sv
// Round-robin scheduler feeding one shared parallel-to-serial path.
module p2s_rr_scheduler
  import p2s_sched_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int GAP_CYCLES = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            request,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] parallelDataIn,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          serialDataOut,
  output logic                          serialValid,
  output logic                          frameStart,
  output logic [$clog2(NUM_REQ)-1:0]    activeSrc,
  output logic                          busy
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int BW = $clog2(DATA_WIDTH);
  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  state_t                state_q, state_d;
  logic [PW-1:0]         lastGrant_q, activeSrc_q;
  logic [NUM_REQ-1:0]    grant_q;
  logic [BW-1:0]         bitCnt_q;
  logic [GW-1:0]         gapCnt_q;

  logic [MAX_REQ-1:0]    reqWide;
  pick_t                 pick;
  logic [PW-1:0]         winner;
  logic [DATA_WIDTH-1:0] winWord;
  logic                  capture;
  logic                  lastBit;
  logic                  gapDone;
  logic                  shiftMsb;

  // Arbitration only matters in IDLE; the search result picks the word to load.
  always_comb begin
    reqWide               = '0;
    reqWide[NUM_REQ-1:0]  = request;
    pick                  = rr_pick(reqWide, int'(lastGrant_q), NUM_REQ);
    winner                = PW'(pick.idx);
    winWord               = parallelDataIn[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
    capture               = (state_q == IDLE) && pick.found;
    lastBit               = (bitCnt_q == '0);
    gapDone               = (gapCnt_q == '0);
  end

  p2s_shift_reg #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_shift (
    .clk  (clk),
    .reset(reset),
    .load (capture),
    .shift(state_q == SHIFT),
    .din  (winWord),
    .msb  (shiftMsb)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decision: capture, shift out all bits, optional idle gap.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (pick.found) state_d = SHIFT;
      SHIFT:   if (lastBit) state_d = (GAP_CYCLES > 0) ? GAP : IDLE;
      GAP:     if (gapDone) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pointer, grant pulse, source index and bit/gap counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      lastGrant_q <= PW'(NUM_REQ - 1);
      activeSrc_q <= '0;
      grant_q     <= '0;
      bitCnt_q    <= '0;
      gapCnt_q    <= '0;
    end else begin
      grant_q <= '0;
      if (capture) begin
        grant_q     <= {{(NUM_REQ-1){1'b0}}, 1'b1} << winner;
        activeSrc_q <= winner;
        lastGrant_q <= winner;
        bitCnt_q    <= BW'(DATA_WIDTH - 1);
      end else if (state_q == SHIFT) begin
        bitCnt_q <= bitCnt_q - 1'b1;
        if (lastBit) begin
          gapCnt_q <= GW'(GAP_CYCLES - 1);
        end
      end else if (state_q == GAP) begin
        gapCnt_q <= gapCnt_q - 1'b1;
      end
    end
  end

  // Outputs decoded purely from registered state.
  always_comb begin
    busy          = (state_q != IDLE);
    serialValid   = (state_q == SHIFT);
    frameStart    = serialValid && (bitCnt_q == BW'(DATA_WIDTH - 1));
    serialDataOut = serialValid && shiftMsb;
    grant         = grant_q;
    activeSrc     = activeSrc_q;
  end

endmodule

// File: tb/tb_p2s_rr_scheduler.sv
// Scoreboard bench for p2s_rr_scheduler: two configurations driven with
// directed and random traffic, checked against a frame-level model.
module tb_p2s_rr_scheduler;

  typedef struct {
    int          src;
    logic [31:0] word;
    int          start;
  } frame_t;

  logic clk;
  int   checkCnt = 0;
  int   passCnt  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Central comparison: counts every check and reports any miss.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCnt++;
    if (act === exp) begin
      passCnt++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at time %0t", name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : cfg
    localparam int NR  = (g == 0) ? 4 : 3;
    localparam int DW  = (g == 0) ? 8 : 4;
    localparam int GAP = (g == 0) ? 1 : 0;
    localparam int PW  = $clog2(NR);

    logic              reset;
    logic [NR-1:0]     request;
    logic [NR*DW-1:0]  parallelDataIn;
    logic [NR-1:0]     grant;
    logic              serialDataOut;
    logic              serialValid;
    logic              frameStart;
    logic [PW-1:0]     activeSrc;
    logic              busy;

    p2s_rr_scheduler #(
      .NUM_REQ   (NR),
      .DATA_WIDTH(DW),
      .GAP_CYCLES(GAP)
    ) dut (
      .clk           (clk),
      .reset         (reset),
      .request       (request),
      .parallelDataIn(parallelDataIn),
      .grant         (grant),
      .serialDataOut (serialDataOut),
      .serialValid   (serialValid),
      .frameStart    (frameStart),
      .activeSrc     (activeSrc),
      .busy          (busy)
    );

    frame_t expQ[$];
    int     edgeCnt;
    int     freeEdge;
    int     lastStart;
    int     lastGrant;
    int     epoch;
    int     w;
    bit     busyExp;
    bit     done = 1'b0;

    // Reference model: at each edge where the scheduler is free, the first
    // pending requester after the previous winner owns the next frame, which
    // starts in the following cycle and occupies DW bits plus GAP idle cycles.
    initial begin
      edgeCnt   = 0;
      freeEdge  = 0;
      lastStart = -1000;
      lastGrant = NR - 1;
      epoch     = 0;
      busyExp   = 1'b0;
      forever begin
        @(posedge clk);
        edgeCnt++;
        if (reset) begin
          lastGrant = NR - 1;
          freeEdge  = edgeCnt + 1;
          lastStart = -1000;
          expQ.delete();
          epoch++;
        end else if (edgeCnt >= freeEdge && request != '0) begin
          w = -1;
          for (int k = 1; k <= NR; k++) begin
            if (w < 0 && request[(lastGrant + k) % NR]) w = (lastGrant + k) % NR;
          end
          expQ.push_back('{src: w, word: 32'(parallelDataIn[w*DW +: DW]), start: edgeCnt});
          lastGrant = w;
          lastStart = edgeCnt;
          freeEdge  = edgeCnt + DW + GAP + 1;
        end
        busyExp = (edgeCnt >= lastStart) && (edgeCnt < lastStart + DW + GAP);
      end
    end

    // Monitor: pops an expected frame at each frameStart and follows its bits.
    initial begin
      int     seenEpoch;
      bit     inFrame;
      int     bitIdx;
      int     activeExp;
      frame_t cur;
      seenEpoch = 0;
      inFrame   = 1'b0;
      bitIdx    = 0;
      activeExp = 0;
      forever begin
        @(negedge clk);
        if (epoch == 0) continue;
        if (epoch != seenEpoch) begin
          seenEpoch = epoch;
          inFrame   = 1'b0;
          activeExp = 0;
        end
        checkOutput("busy", busy, busyExp);
        if (serialValid && frameStart) begin
          checkOutput("overlapFrame", inFrame, 0);
          if (expQ.size() == 0) begin
            checkOutput("unexpectedFrame", frameStart, 0);
          end else begin
            cur = expQ.pop_front();
            checkOutput("startCycle", edgeCnt, cur.start);
            checkOutput("grantOneHot", grant, 32'd1 << cur.src);
            activeExp = cur.src;
            inFrame   = 1'b1;
            bitIdx    = DW - 1;
          end
        end else begin
          checkOutput("grantIdle", grant, 0);
        end
        if (serialValid) begin
          if (!inFrame) begin
            checkOutput("strayValid", serialValid, 0);
          end else begin
            checkOutput("serialBit", serialDataOut, cur.word[bitIdx]);
            bitIdx--;
            if (bitIdx < 0) inFrame = 1'b0;
          end
        end else begin
          checkOutput("validDropped", inFrame, 0);
          inFrame = 1'b0;
          checkOutput("dataIdle", serialDataOut, 0);
          checkOutput("frameStartIdle", frameStart, 0);
        end
        checkOutput("activeSrc", activeSrc, activeExp);
        while (expQ.size() > 0 && expQ[0].start < edgeCnt) begin
          checkOutput("frameMissing", edgeCnt, expQ[0].start);
          void'(expQ.pop_front());
        end
      end
    end

    // Drive one request/data pattern and hold it for a number of cycles.
    task automatic applyStimulus(input int req, input logic [31:0] data, input int cycles);
      request        = req[NR-1:0];
      parallelDataIn = data[NR*DW-1:0];
      repeat (cycles) @(negedge clk);
    endtask

    // Directed scenarios first, then random traffic with occasional resets.
    initial begin
      logic [31:0] rnd;
      reset          = 1'b1;
      request        = '0;
      parallelDataIn = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      checkOutput("resetBusy", busy, 0);
      checkOutput("resetValid", serialValid, 0);
      checkOutput("resetGrant", grant, 0);
      checkOutput("resetActiveSrc", activeSrc, 0);
      if (g == 0) begin
        applyStimulus(4'b0001, 32'h000000A5, 1);
        applyStimulus(0, 32'h000000A5, 12);
        applyStimulus(4'b1111, 32'h08040201, 45);
        applyStimulus(0, 32'h08040201, 12);
        applyStimulus(4'b1000, 32'h11223344, 1);
        applyStimulus(0, 32'h11223344, 11);
        applyStimulus(4'b0101, 32'h5A6B7C8D, 25);
        applyStimulus(0, 32'h5A6B7C8D, 12);
        applyStimulus(4'b0011, 32'hC3C33C3C, 3);
        applyStimulus(4'b0001, 32'hC3C33C3C, 12);
        applyStimulus(0, 32'hC3C33C3C, 12);
        applyStimulus(4'b0010, 32'h0000F000, 1);
        applyStimulus(0, 32'h0000F000, 4);
      end else begin
        applyStimulus(3'b010, 32'h00000AC5, 30);
        applyStimulus(0, 32'h00000AC5, 6);
        applyStimulus(3'b100, 32'h00000369, 1);
        applyStimulus(0, 32'h00000369, 5);
        applyStimulus(3'b101, 32'h00000369, 12);
        applyStimulus(0, 32'h00000369, 6);
        applyStimulus(3'b010, 32'h000009E7, 1);
        applyStimulus(0, 32'h000009E7, 2);
      end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checkOutput("midResetBusy", busy, 0);
      checkOutput("midResetValid", serialValid, 0);
      applyStimulus((g == 0) ? 4'b1000 : 3'b100, 32'hB7B7B7B7, 1);
      applyStimulus(0, 32'hB7B7B7B7, 12);
      for (int i = 0; i < 700; i++) begin
        @(negedge clk);
        reset = ($urandom_range(0, 299) == 0);
        for (int b = 0; b < NR; b++) begin
          if ($urandom_range(0, 5) == 0) request[b] = ~request[b];
        end
        if ($urandom_range(0, 3) == 0) begin
          rnd            = $urandom();
          parallelDataIn = rnd[NR*DW-1:0];
        end
      end
      @(negedge clk);
      reset   = 1'b0;
      request = '0;
      repeat (DW + GAP + 5) @(negedge clk);
      checkOutput("leftoverFrames", expQ.size(), 0);
      done = 1'b1;
    end
  end

  // Wait for both configurations with a bounded budget, then summarise.
  initial begin
    int waited;
    waited = 0;
    while (!(cfg[0].done && cfg[1].done) && waited < 20000) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("benchTimeout", {31'd0, cfg[0].done & cfg[1].done}, 1);
    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
